// File: rtl/scr1_timer_mc.sv
// scr1_timer_mc: multi-channel memory-mapped machine timer with prescaler and periodic compare
package scr1_timer_mc_pkg;
   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;
   localparam logic SCR1_MEM_CMD_RD = 1'b0;
   localparam logic SCR1_MEM_CMD_WR = 1'b1;
   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;
   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

module scr1_timer_mc
   import scr1_timer_mc_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DIV_WIDTH  = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ext_tick,
   input  logic                        dmem_req,
   input  logic                        dmem_cmd,
   input  type_scr1_mem_width_e        dmem_width,
   input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
   input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
   output logic                        dmem_req_ack,
   output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
   output type_scr1_mem_resp_e         dmem_resp,
   output logic [63:0]                 timer_val,
   output logic [NUM_CH-1:0]           timer_irq,
   output logic                        timer_irq_any
);
   localparam int AW4 = ADDR_WIDTH - 4;

   logic                  ctrl_en, ctrl_ext;
   logic [DIV_WIDTH-1:0]  divider, cnt;
   logic [63:0]           mtime, mtime_inc;
   logic [NUM_CH-1:0]     status, enable, arm, periodic, hit, ch_sel;
   logic [63:0]           cmp [NUM_CH];
   logic [31:0]           period [NUM_CH];
   logic                  ext_s1, ext_s2, ext_s3, ext_pulse, cnt_en, tick;
   logic [ADDR_WIDTH-1:0] off;
   logic [AW4-1:0]        blk, ch_idx;
   logic [1:0]            fld;
   logic                  blk0, blk1, ch_hit, valid, wr;
   logic                  we_ctrl, we_div, we_lo, we_hi, we_sts, we_ena;
   logic [31:0]           rmux;
   logic                  unused_addr;

   assign off       = dmem_addr[ADDR_WIDTH-1:0];
   assign blk       = off[ADDR_WIDTH-1:4];
   assign fld       = off[3:2];
   assign ch_idx    = blk - AW4'(2);
   assign blk0      = blk == AW4'(0);
   assign blk1      = blk == AW4'(1);
   assign ch_hit    = blk >= AW4'(2) && blk < AW4'(2 + NUM_CH);
   assign valid     = dmem_width == SCR1_MEM_WIDTH_WORD && off[1:0] == 2'b00 && (blk0 || (blk1 && !fld[1]) || ch_hit);
   assign wr        = dmem_req && dmem_cmd == SCR1_MEM_CMD_WR && valid;
   assign we_ctrl   = wr && blk0 && fld == 2'd0;
   assign we_div    = wr && blk0 && fld == 2'd1;
   assign we_lo     = wr && blk0 && fld == 2'd2;
   assign we_hi     = wr && blk0 && fld == 2'd3;
   assign we_sts    = wr && blk1 && fld == 2'd0;
   assign we_ena    = wr && blk1 && fld == 2'd1;
   assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:ADDR_WIDTH];

   assign ext_pulse = ext_s2 && !ext_s3;
   assign cnt_en    = ctrl_en && (ctrl_ext ? ext_pulse : 1'b1);
   assign tick      = cnt_en && cnt == '0;
   assign mtime_inc = mtime + 64'(tick);

   assign dmem_req_ack  = 1'b1;
   assign timer_val     = mtime;
   assign timer_irq     = status & enable;
   assign timer_irq_any = |timer_irq;

   // register read multiplexer, sampled into dmem_rdata on the request cycle
   always_comb begin
      rmux = '0;
      if (blk0)
         rmux = fld == 2'd0 ? {30'd0, ctrl_ext, ctrl_en} : fld == 2'd1 ? 32'(divider) : fld == 2'd2 ? mtime[31:0] : mtime[63:32];
      else if (blk1)
         rmux = fld[0] ? 32'(enable) : 32'(status);
      for (int i = 0; i < NUM_CH; i++)
         if (ch_sel[i])
            rmux = fld == 2'd0 ? cmp[i][31:0] : fld == 2'd1 ? cmp[i][63:32] : fld == 2'd2 ? period[i] : {30'd0, periodic[i], arm[i]};
   end

   // registered bus response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
         dmem_rdata <= '0;
      end else begin
         dmem_resp  <= !dmem_req ? SCR1_MEM_RESP_NOTRDY : valid ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
         dmem_rdata <= (dmem_req && valid && dmem_cmd == SCR1_MEM_CMD_RD) ? rmux : '0;
      end
   end

   // ext_tick synchroniser plus edge-detect flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {ext_s3, ext_s2, ext_s1} <= 3'b000;
      else        {ext_s3, ext_s2, ext_s1} <= {ext_s2, ext_s1, ext_tick};
   end

   // control, prescaler and mtime; a half written during a tick still takes the other half of the increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en  <= 1'b1;
         ctrl_ext <= 1'b0;
         divider  <= '0;
         cnt      <= '0;
         mtime    <= '0;
      end else begin
         if (we_ctrl) {ctrl_ext, ctrl_en} <= dmem_wdata[1:0];
         if (we_div) divider <= dmem_wdata[DIV_WIDTH-1:0];
         cnt <= we_div ? dmem_wdata[DIV_WIDTH-1:0] : tick ? divider : cnt_en ? cnt - DIV_WIDTH'(1) : cnt;
         mtime[31:0]  <= we_lo ? dmem_wdata : mtime_inc[31:0];
         mtime[63:32] <= we_hi ? dmem_wdata : mtime_inc[63:32];
      end
   end

   // sticky status (a same-cycle set beats the W1C clear) and enable mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status <= '0;
         enable <= '0;
      end else begin
         if (we_ena) enable <= dmem_wdata[NUM_CH-1:0];
         status <= (status & ~(we_sts ? dmem_wdata[NUM_CH-1:0] : '0)) | hit;
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic [63:0] cmp_r;
      logic [31:0] period_r;
      logic        arm_r, periodic_r, we_cl, we_ch, we_per, we_cc, match;
      assign ch_sel[n]   = ch_hit && ch_idx == AW4'(n);
      assign we_cl       = wr && ch_sel[n] && fld == 2'd0;
      assign we_ch       = wr && ch_sel[n] && fld == 2'd1;
      assign we_per      = wr && ch_sel[n] && fld == 2'd2;
      assign we_cc       = wr && ch_sel[n] && fld == 2'd3;
      assign match       = arm_r && mtime >= cmp_r;
      assign hit[n]      = match && !(we_cl || we_ch || we_cc);
      assign cmp[n]      = cmp_r;
      assign period[n]   = period_r;
      assign arm[n]      = arm_r;
      assign periodic[n] = periodic_r;

      // channel compare state; software writes pre-empt a same-cycle match
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cmp_r      <= '1;
            period_r   <= '0;
            arm_r      <= 1'b0;
            periodic_r <= 1'b0;
         end else begin
            if (we_cl) cmp_r[31:0] <= dmem_wdata;
            if (we_ch) cmp_r[63:32] <= dmem_wdata;
            if (hit[n] && periodic_r) cmp_r <= cmp_r + 64'(period_r);
            if (we_per) period_r <= dmem_wdata;
            if (we_cc) {periodic_r, arm_r} <= dmem_wdata[1:0];
            else if (hit[n] && !periodic_r) arm_r <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_scr1_timer_mc.sv
// tb_scr1_timer_mc: directed self-checking bench for scr1_timer_mc
module tb_scr1_timer_mc;
   import scr1_timer_mc_pkg::*;
   localparam int NUM_CH = 4;

   logic                 clk = 1'b0, rst_n = 1'b0, ext_tick = 1'b0, dmem_req = 1'b0, dmem_cmd = 1'b0;
   type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
   logic [31:0]          dmem_addr = '0, dmem_wdata = '0;
   logic                 dmem_req_ack, timer_irq_any;
   logic [31:0]          dmem_rdata;
   type_scr1_mem_resp_e  dmem_resp;
   logic [63:0]          timer_val;
   logic [NUM_CH-1:0]    timer_irq;
   int                   errors = 0, checks = 0;

   typedef struct {
      logic        c;
      logic [1:0]  w;
      logic [31:0] a, d;
      logic [1:0]  resp;
      logic [31:0] q;
      string       name;
   } vec_t;
   vec_t tv[$];

   scr1_timer_mc #(.NUM_CH(NUM_CH), .DIV_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .ext_tick(ext_tick), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
      .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .timer_val(timer_val), .timer_irq(timer_irq),
      .timer_irq_any(timer_irq_any)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus(input logic c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                      output logic [1:0] r, output logic [31:0] q);
      dmem_req = 1'b1; dmem_cmd = c; dmem_width = type_scr1_mem_width_e'(w); dmem_addr = a; dmem_wdata = d;
      @(negedge clk);
      r = dmem_resp;
      q = dmem_rdata;
      dmem_req = 1'b0;
   endtask

   task automatic wr32(input logic [31:0] a, input logic [31:0] d);
      logic [1:0] r;
      logic [31:0] q;
      bus(1'b1, 2'd2, a, d, r, q);
      check($sformatf("wr resp @0x%0h", a), 64'(r), 64'(1));
   endtask

   task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp);
      logic [1:0] r;
      logic [31:0] q;
      bus(1'b0, 2'd2, a, 32'd0, r, q);
      check($sformatf("rd resp @0x%0h", a), 64'(r), 64'(1));
      check($sformatf("rd data @0x%0h", a), 64'(q), 64'(exp));
   endtask

   task automatic wait_irq(input int ch, output logic [63:0] mt);
      int n = 0;
      while (!timer_irq[ch] && n < 100) begin
         @(negedge clk);
         n++;
      end
      mt = timer_val;
      check($sformatf("irq%0d rise within bound", ch), 64'(timer_irq[ch]), 64'(1));
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] q, hi_b;
      logic [63:0] m0, mt;

      tv.push_back('{1'b0, 2'd2, 32'h00, 32'h0, 2'd1, 32'h1,        "CONTROL reset"});
      tv.push_back('{1'b0, 2'd2, 32'h04, 32'h0, 2'd1, 32'h0,        "DIVIDER reset"});
      tv.push_back('{1'b0, 2'd2, 32'h20, 32'h0, 2'd1, 32'hFFFFFFFF, "CMPLO0 reset"});
      tv.push_back('{1'b0, 2'd2, 32'h10, 32'h0, 2'd1, 32'h0,        "IRQ_STATUS reset"});
      tv.push_back('{1'b0, 2'd2, 32'h14, 32'h0, 2'd1, 32'h0,        "IRQ_ENABLE reset"});
      tv.push_back('{1'b0, 2'd2, 32'h54, 32'h0, 2'd1, 32'hFFFFFFFF, "CMPHI3 reset"});
      tv.push_back('{1'b0, 2'd2, 32'h58, 32'h0, 2'd1, 32'h0,        "PERIOD3 reset"});
      tv.push_back('{1'b0, 2'd2, 32'h5C, 32'h0, 2'd1, 32'h0,        "CH_CTRL3 reset"});
      tv.push_back('{1'b0, 2'd2, 32'h10000000, 32'h0, 2'd1, 32'h1,  "upper addr ignored"});
      tv.push_back('{1'b0, 2'd0, 32'h08, 32'h0, 2'd2, 32'h0,        "byte read"});
      tv.push_back('{1'b0, 2'd1, 32'h00, 32'h0, 2'd2, 32'h0,        "hword read"});
      tv.push_back('{1'b0, 2'd2, 32'h02, 32'h0, 2'd2, 32'h0,        "misaligned read"});
      tv.push_back('{1'b0, 2'd2, 32'h18, 32'h0, 2'd2, 32'h0,        "hole 0x18"});
      tv.push_back('{1'b0, 2'd2, 32'h1C, 32'h0, 2'd2, 32'h0,        "hole 0x1C"});
      tv.push_back('{1'b0, 2'd2, 32'h60, 32'h0, 2'd2, 32'h0,        "channel NUM_CH read"});
      tv.push_back('{1'b1, 2'd2, 32'h60, 32'h5, 2'd2, 32'h0,        "channel NUM_CH write"});
      tv.push_back('{1'b1, 2'd2, 32'h15, 32'hFF, 2'd2, 32'h0,       "misaligned write"});
      tv.push_back('{1'b1, 2'd0, 32'h14, 32'hFF, 2'd2, 32'h0,       "byte write"});
      tv.push_back('{1'b0, 2'd2, 32'h14, 32'h0, 2'd1, 32'h0,        "ENABLE untouched"});
      tv.push_back('{1'b0, 2'd2, 32'h0C, 32'h0, 2'd1, 32'h0,        "MTIMEHI small"});

      repeat (2) @(negedge clk);
      check("reset resp", 64'(dmem_resp), 64'(0));
      check("reset rdata", 64'(dmem_rdata), 64'(0));
      check("reset timer_val", timer_val, 64'(0));
      check("reset timer_irq", 64'(timer_irq), 64'(0));
      check("reset timer_irq_any", 64'(timer_irq_any), 64'(0));
      check("req_ack", 64'(dmem_req_ack), 64'(1));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle resp", 64'(dmem_resp), 64'(0));

      foreach (tv[i]) begin
         bus(tv[i].c, tv[i].w, tv[i].a, tv[i].d, r, q);
         check({tv[i].name, " resp"}, 64'(r), 64'(tv[i].resp));
         check({tv[i].name, " rdata"}, 64'(q), 64'(tv[i].q));
      end

      // prescaler: DIVIDER=3 -> one increment per 4 cycles
      wr32(32'h04, 32'd3);
      m0 = timer_val;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("prescale k=%0d", k), timer_val, m0 + 64'(k / 4));
      end
      repeat (3) @(negedge clk);
      hi_b = timer_val[63:32];
      wr32(32'h08, 32'hFFFFFFFF);
      check("LO write on tick", timer_val, {hi_b, 32'hFFFFFFFF});
      repeat (3) @(negedge clk);
      check("LO hold", timer_val, {hi_b, 32'hFFFFFFFF});
      @(negedge clk);
      check("LO carry", timer_val, {hi_b + 32'd1, 32'h0});

      // channel 0 one-shot
      wr32(32'h00, 32'd0);
      wr32(32'h04, 32'd0);
      wr32(32'h0C, 32'd0);
      wr32(32'h08, 32'd95);
      wr32(32'h20, 32'd100);
      wr32(32'h24, 32'd0);
      wr32(32'h2C, 32'd1);
      wr32(32'h14, 32'd1);
      wr32(32'h00, 32'd1);
      wait_irq(0, mt);
      check("ch0 irq at mtime", mt, 64'd101);
      check("ch0 irq_any", 64'(timer_irq_any), 64'(1));
      rd_chk(32'h2C, 32'd0);
      rd_chk(32'h10, 32'd1);
      wr32(32'h10, 32'd1);
      check("ch0 irq after W1C", 64'(timer_irq), 64'(0));
      check("ch0 any after W1C", 64'(timer_irq_any), 64'(0));

      // channel 1 periodic
      wr32(32'h00, 32'd0);
      wr32(32'h08, 32'd40);
      wr32(32'h30, 32'd50);
      wr32(32'h34, 32'd0);
      wr32(32'h38, 32'd20);
      wr32(32'h3C, 32'd3);
      wr32(32'h14, 32'd2);
      wr32(32'h00, 32'd1);
      for (int p = 0; p < 3; p++) begin
         wait_irq(1, mt);
         check($sformatf("ch1 match %0d", p), mt, 64'(51 + 20 * p));
         wr32(32'h10, 32'd2);
         check($sformatf("ch1 cleared %0d", p), 64'(timer_irq[1]), 64'(0));
      end
      rd_chk(32'h30, 32'd110);
      wr32(32'h3C, 32'd0);

      // external tick source
      wr32(32'h04, 32'd0);
      wr32(32'h00, 32'd3);
      repeat (3) @(negedge clk);
      m0 = timer_val;
      for (int e = 0; e < 5; e++) begin
         ext_tick = 1'b1;
         repeat (3) @(negedge clk);
         ext_tick = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("ext 5 edges", timer_val, m0 + 64'd5);
      ext_tick = 1'b1;
      repeat (10) @(negedge clk);
      check("ext steady high", timer_val, m0 + 64'd6);
      ext_tick = 1'b0;
      repeat (10) @(negedge clk);
      check("ext steady low", timer_val, m0 + 64'd6);
      rd_chk(32'h00, 32'd3);

      // channel 2: W1C in the match cycle loses to the set
      wr32(32'h00, 32'd0);
      wr32(32'h0C, 32'd0);
      wr32(32'h08, 32'd150);
      wr32(32'h40, 32'd200);
      wr32(32'h44, 32'd0);
      wr32(32'h14, 32'hC);
      wr32(32'h4C, 32'd1);
      wr32(32'h08, 32'd200);
      wr32(32'h10, 32'd4);
      check("ch2 set beats W1C", 64'(timer_irq), 64'h4);
      rd_chk(32'h10, 32'd4);
      rd_chk(32'h4C, 32'd0);
      wr32(32'h10, 32'd4);
      check("ch2 W1C later", 64'(timer_irq), 64'(0));

      // channel 3: software write in the match cycle wins
      wr32(32'h50, 32'd300);
      wr32(32'h54, 32'd0);
      wr32(32'h5C, 32'd1);
      wr32(32'h08, 32'd300);
      wr32(32'h50, 32'd500);
      check("ch3 write beats match", 64'(timer_irq), 64'(0));
      rd_chk(32'h5C, 32'd1);
      rd_chk(32'h50, 32'd500);
      rd_chk(32'h10, 32'd0);

      // asynchronous reset with a response in flight
      dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD; dmem_addr = 32'h00;
      #6;
      check("pre-reset resp", 64'(dmem_resp), 64'(1));
      rst_n = 1'b0;
      #1;
      check("async reset resp", 64'(dmem_resp), 64'(0));
      check("async reset timer_val", timer_val, 64'(0));
      dmem_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset resp", 64'(dmem_resp), 64'(0));
      rd_chk(32'h20, 32'hFFFFFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/scr1_timer_mc.md
Name: scr1_timer_mc

Overview:
- Memory-mapped multi-channel machine timer on the dmem bus.
- One shared 64-bit mtime counter with a programmable prescaler, clocked either from clk or from a synchronised external tick.
- NUM_CH independent 64-bit compare channels, each one-shot or periodic (hardware auto-reload).
- Sticky per-channel interrupt status with enable mask. Provides timer_val to the core and per-channel plus aggregate IRQ lines to the interrupt controller.

Parameters:
- NUM_CH, 4, number of compare channels (1..8).
- DIV_WIDTH, 16, prescaler width in bits (1..32).
- ADDR_WIDTH, 8, decoded dmem address bits. Must cover 0x20+16*NUM_CH-1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ext_tick  in  1  asynchronous external time reference; a rising edge is one tick
- dmem_req  in  1  request strobe
- dmem_cmd  in  1  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR
- dmem_width  in  type_scr1_mem_width_e  access width
- dmem_addr  in  SCR1_DMEM_AWIDTH  address; low ADDR_WIDTH bits decoded
- dmem_wdata  in  SCR1_DMEM_DWIDTH  write data
- dmem_req_ack  out  1  constant 1
- dmem_rdata  out  SCR1_DMEM_DWIDTH  read data, registered
- dmem_resp  out  2  SCR1_MEM_RESP_*, registered
- timer_val  out  64  current mtime
- timer_irq  out  NUM_CH  per-channel interrupt = status & enable
- timer_irq_any  out  1  OR of timer_irq

Behaviour:
- Register map (word access only):
  - 0x00 CONTROL: [0] en (reset 1), [1] clksrc_ext (reset 0).
  - 0x04 DIVIDER: [DIV_WIDTH-1:0], reset 0.
  - 0x08 MTIMELO.
  - 0x0C MTIMEHI.
  - 0x10 IRQ_STATUS: W1C.
  - 0x14 IRQ_ENABLE: reset 0.
  - Channel n at 0x20+16n: +0 CMPLO, +4 CMPHI, +8 PERIOD (32 b), +C CH_CTRL ([0] arm, [1] periodic).
  - Channel reset: CMP=all-ones, PERIOD=0, CH_CTRL=0.
  - Unused bits read 0.
- Bus timing:
  - Response is registered and appears 1 cycle after dmem_req.
  - A valid access returns RDY_OK. Reads return register contents sampled in the request cycle.
  - Invalid access (width != WORD, addr[1:0] != 0, unmapped offset, channel index >= NUM_CH) returns RDY_ER with no side effects.
  - No request: resp=NOTRDY and rdata=0 next cycle.
  - Reset values: dmem_resp=NOTRDY, dmem_rdata=0, timer_val=0, timer_irq=0, timer_irq_any=0.
- Tick source:
  - ext_tick passes through a 2-FF synchroniser, then rising-edge detect (3rd flop), giving ext_pulse.
  - Synchroniser flops clear on reset.
  - cnt_en = en & (clksrc_ext ? ext_pulse : 1).
- Prescaler:
  - Down-counter, reset 0.
  - Priority: DIVIDER write loads the written value > (cnt_en & cnt==0) reloads DIVIDER > cnt_en decrements.
  - tick = cnt_en & cnt==0, so mtime advances every DIVIDER+1 enabled events.
- mtime:
  - Increments by 1 on tick; wraps from all-ones to 0.
  - A write to LO or HI in the same cycle as tick: the written half takes wdata, the other half takes the incremented value's half.
- Channel match:
  - match_n = arm_n & (mtime >= CMP_n), unsigned 64-bit, evaluated on registered values.
  - On match the next clock sets status[n].
  - One-shot (periodic=0): arm_n is cleared.
  - Periodic: CMP_n <= CMP_n + zero-extended PERIOD_n (mod 2^64) and arm stays set.
  - If mtime is still >= the new CMP, the channel matches again next cycle (catch-up, one status set per cycle, status already sticky).
  - Periodic with PERIOD=0 re-matches every cycle; this is legal.
- Simultaneous events:
  - A software write to CMPLO/CMPHI/CH_CTRL of channel n in the same cycle as match_n: the write wins; no reload, no arm clear, status not set that cycle.
  - W1C clear of status[n] in the same cycle as a status set: set wins.
- IRQ outputs are combinational from registered status & enable, so timer_irq rises 1 cycle after the match cycle.
- Reset asserted mid-operation: all state returns to reset values asynchronously, including an in-flight response (next resp=NOTRDY).

Test Plan:
- Reset, then read CONTROL/DIVIDER/CMPLO0/IRQ_STATUS -> 0x1 / 0 / 0xFFFFFFFF / 0, each RDY_OK one cycle after the request. A byte read of 0x08 -> RDY_ER.
- DIVIDER=3, clk source -> mtime increments once every 4 cycles. Write MTIMELO=0xFFFFFFFF on the cycle of a tick -> LO=0xFFFFFFFF, HI unchanged+carry-free per rule.
- Ch0: CMP=100, one-shot, arm, IRQ_ENABLE=1 -> at mtime=100, status[0]=1 next cycle, timer_irq[0]=1, arm cleared. W1C 0x1 -> irq drops next cycle.
- Ch1: CMP=50, PERIOD=20, periodic -> status sets at 50, 70, 90. CMP reads 110 after the third match.
- clksrc_ext=1, DIVIDER=0, toggle ext_tick 5 rising edges -> mtime +5. Steady high/low levels add nothing.
- W1C status[2] on the same cycle ch2 matches -> status[2] stays 1. Offset 0x20+16*NUM_CH -> RDY_ER.
